// File: rtl/ballot_pkg.sv
// Shared types and helpers for the ballot session controller.
// State encoding, candidate vector limits and selection-shape checks.
package ballot_pkg;

    // Widest candidate vector supported; narrower vectors are zero-extended.
    localparam int MAX_CAND = 8;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_SELECT  = 3'd1;
    localparam logic [2:0] ENC_REVIEW  = 3'd2;
    localparam logic [2:0] ENC_COMMIT  = 3'd3;
    localparam logic [2:0] ENC_RELEASE = 3'd4;
    localparam logic [2:0] ENC_CLOSED  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = ENC_IDLE,
        ST_SELECT  = ENC_SELECT,
        ST_REVIEW  = ENC_REVIEW,
        ST_COMMIT  = ENC_COMMIT,
        ST_RELEASE = ENC_RELEASE,
        ST_CLOSED  = ENC_CLOSED
    } state_e;

    // True when exactly one bit of the selection is set.
    function automatic logic is_one_hot(input logic [MAX_CAND-1:0] vec);
        return (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
    endfunction

    // True when two or more bits of the selection are set.
    function automatic logic is_multi_hot(input logic [MAX_CAND-1:0] vec);
        return (vec != 8'd0) && ((vec & (vec - 8'd1)) != 8'd0);
    endfunction

endpackage

// File: rtl/ballot_session_ctrl_if.sv
// Voter-facing inputs and tally-facing outputs of the session controller.
// BALLOT_ABSTAIN_EN adds the abstain_evt strobe.
interface ballot_session_ctrl_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 4
);
    logic                auth_pin;
    logic [NUM_CAND-1:0] cand_sel;
    logic                confirm;
    logic                cancel;
    logic                close_poll;
    logic [NUM_CAND-1:0] vote_inc;
    logic                ballot_open;
    logic [NUM_CAND-1:0] sel_q;
    logic [CNT_W-1:0]    voter_count;
    logic                poll_closed;
    logic                err_multi;
    logic                timeout_evt;
`ifdef BALLOT_ABSTAIN_EN
    logic                abstain_evt;

    modport master (
        output auth_pin, cand_sel, confirm, cancel, close_poll,
        input  vote_inc, ballot_open, sel_q, voter_count, poll_closed,
               err_multi, timeout_evt, abstain_evt
    );

    modport slave (
        input  auth_pin, cand_sel, confirm, cancel, close_poll,
        output vote_inc, ballot_open, sel_q, voter_count, poll_closed,
               err_multi, timeout_evt, abstain_evt
    );
`else
    modport master (
        output auth_pin, cand_sel, confirm, cancel, close_poll,
        input  vote_inc, ballot_open, sel_q, voter_count, poll_closed,
               err_multi, timeout_evt
    );

    modport slave (
        input  auth_pin, cand_sel, confirm, cancel, close_poll,
        output vote_inc, ballot_open, sel_q, voter_count, poll_closed,
               err_multi, timeout_evt
    );
`endif
endinterface

// File: rtl/ballot_timeout_timer.sv
// Session idle timer: counts while run is high, restarts on clear,
// flags expiry on the TIMEOUT_CYC-th counted cycle.
module ballot_timeout_timer #(
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] LAST_VAL = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] count_r;

    // Idle-cycle counter, restarted whenever the session changes phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {TMR_W{1'b0}};
        end else if (clear) begin
            count_r <= {TMR_W{1'b0}};
        end else if (run) begin
            count_r <= count_r + TMR_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry is only meaningful while a session phase is being timed.
    always_comb begin
        expire = 1'b0;
        if (run && (count_r == LAST_VAL)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/ballot_session_ctrl.sv
// Per-voter session sequencer: authentication, selection, review, commit.
// Guarantees at most one tally strobe per authenticated session and
// enforces idle timeout, turnout limit and poll closure.
// Optional feature macro: BALLOT_ABSTAIN_EN (confirm with no selection
// in SELECT commits an abstention and pulses abstain_evt).
module ballot_session_ctrl
    import ballot_pkg::*;
#(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 4,
    parameter int MAX_TURNOUT = 10,
    parameter int TIMEOUT_CYC = 50000000
) (
    input logic                  clk,
    input logic                  reset,
    ballot_session_ctrl_if.slave bus
);
    state_e              state_r;
    state_e              state_nxt_s;
    logic [NUM_CAND-1:0] sel_q_r;
    logic [NUM_CAND-1:0] vote_inc_r;
    logic [CNT_W-1:0]    voter_count_r;
    logic                ballot_open_r;
    logic                poll_closed_r;
    logic                err_multi_r;
    logic                timeout_evt_r;
    logic                close_pend_r;
    logic                multi_seen_r;

    logic [MAX_CAND-1:0] cand_ext_s;
    logic                one_hot_s;
    logic                multi_hot_s;
    logic                buttons_idle_s;
    logic                close_req_s;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic                at_limit_s;
    logic                timer_run_s;
    logic                timer_clear_s;
    logic                expire_s;
    logic                load_sel_s;
    logic                err_set_s;
    logic                tmo_set_s;

    assign cand_ext_s     = MAX_CAND'(bus.cand_sel);
    assign one_hot_s      = is_one_hot(cand_ext_s);
    assign multi_hot_s    = is_multi_hot(cand_ext_s);
    assign buttons_idle_s = !bus.auth_pin && !bus.confirm && (bus.cand_sel == {NUM_CAND{1'b0}});
    assign close_req_s    = close_pend_r || bus.close_poll;
    assign cnt_inc_s      = voter_count_r + CNT_W'(1);
    assign at_limit_s     = (cnt_inc_s == CNT_W'(MAX_TURNOUT));
    assign timer_run_s    = (state_r == ST_SELECT) || (state_r == ST_REVIEW);
    assign timer_clear_s  = !timer_run_s || (state_nxt_s != state_r) || bus.cancel;

    ballot_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (timer_run_s),
        .clear  (timer_clear_s),
        .expire (expire_s)
    );

    // Session state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus the single-cycle event requests.
    always_comb begin
        state_nxt_s = state_r;
        load_sel_s  = 1'b0;
        err_set_s   = 1'b0;
        tmo_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (close_req_s) begin
                    state_nxt_s = ST_CLOSED;
                end else if (bus.auth_pin) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (bus.cancel) begin
                    state_nxt_s = close_req_s ? ST_CLOSED : ST_IDLE;
                end else if (one_hot_s) begin
                    state_nxt_s = ST_REVIEW;
                    load_sel_s  = 1'b1;
`ifdef BALLOT_ABSTAIN_EN
                end else if (bus.confirm && (bus.cand_sel == {NUM_CAND{1'b0}})) begin
                    state_nxt_s = ST_COMMIT;
`endif
                end else if (expire_s) begin
                    state_nxt_s = close_req_s ? ST_CLOSED : ST_IDLE;
                    tmo_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_SELECT;
                    // Report a multi-hot press once, not every cycle it is held.
                    err_set_s   = multi_hot_s && !multi_seen_r;
                end
            end
            ST_REVIEW: begin
                if (bus.cancel) begin
                    state_nxt_s = ST_SELECT;
                end else if (bus.confirm) begin
                    state_nxt_s = ST_COMMIT;
                end else if (expire_s) begin
                    state_nxt_s = close_req_s ? ST_CLOSED : ST_IDLE;
                    tmo_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_REVIEW;
                end
            end
            ST_COMMIT: begin
                if (at_limit_s || close_pend_r) begin
                    state_nxt_s = ST_CLOSED;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (bus.close_poll) begin
                    state_nxt_s = ST_CLOSED;
                end else if (buttons_idle_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_CLOSED: begin
                state_nxt_s = ST_CLOSED;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latched selection: loaded on entry to REVIEW, zero outside REVIEW/COMMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q_r <= {NUM_CAND{1'b0}};
        end else if (load_sel_s) begin
            sel_q_r <= bus.cand_sel;
        end else if ((state_nxt_s == ST_REVIEW) || (state_nxt_s == ST_COMMIT)) begin
            sel_q_r <= sel_q_r;
        end else begin
            sel_q_r <= {NUM_CAND{1'b0}};
        end
    end

    // Tally strobe and turnout counter, both driven from the COMMIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_inc_r    <= {NUM_CAND{1'b0}};
            voter_count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_COMMIT) begin
            vote_inc_r    <= sel_q_r;
            voter_count_r <= cnt_inc_s;
        end else begin
            vote_inc_r    <= {NUM_CAND{1'b0}};
            voter_count_r <= voter_count_r;
        end
    end

    // Status levels follow the state being entered; events are one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ballot_open_r <= 1'b0;
            poll_closed_r <= 1'b0;
            err_multi_r   <= 1'b0;
            timeout_evt_r <= 1'b0;
            multi_seen_r  <= 1'b0;
        end else begin
            ballot_open_r <= (state_nxt_s == ST_SELECT) || (state_nxt_s == ST_REVIEW);
            poll_closed_r <= (state_nxt_s == ST_CLOSED);
            err_multi_r   <= err_set_s;
            timeout_evt_r <= tmo_set_s;
            multi_seen_r  <= (state_r == ST_SELECT) && multi_hot_s;
        end
    end

    // A close request during an open ballot is deferred until the session ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            close_pend_r <= 1'b0;
        end else if (bus.close_poll && timer_run_s) begin
            close_pend_r <= 1'b1;
        end else begin
            close_pend_r <= close_pend_r;
        end
    end

    assign bus.vote_inc    = vote_inc_r;
    assign bus.ballot_open = ballot_open_r;
    assign bus.sel_q       = sel_q_r;
    assign bus.voter_count = voter_count_r;
    assign bus.poll_closed = poll_closed_r;
    assign bus.err_multi   = err_multi_r;
    assign bus.timeout_evt = timeout_evt_r;

`ifdef BALLOT_ABSTAIN_EN
    logic abstain_evt_r;

    // Abstention marker: a commit carrying an empty selection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abstain_evt_r <= 1'b0;
        end else begin
            abstain_evt_r <= (state_r == ST_COMMIT) && (sel_q_r == {NUM_CAND{1'b0}});
        end
    end

    assign bus.abstain_evt = abstain_evt_r;
`endif

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Directed bench for ballot_session_ctrl (MAX_TURNOUT=3, TIMEOUT_CYC=16).
module tb_ballot_session_ctrl;
    localparam int NC = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    ballot_session_ctrl_if #(.NUM_CAND(NC), .CNT_W(CW)) bif ();

    ballot_session_ctrl #(
        .NUM_CAND    (NC),
        .CNT_W       (CW),
        .MAX_TURNOUT (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] vote, input logic open,
                           input logic [3:0] selq, input logic [3:0] cnt, input logic closed,
                           input logic err, input logic tmo);
        chk({tag, ".vote_inc"},    32'(bif.vote_inc),    32'(vote));
        chk({tag, ".ballot_open"}, 32'(bif.ballot_open), 32'(open));
        chk({tag, ".sel_q"},       32'(bif.sel_q),       32'(selq));
        chk({tag, ".voter_count"}, 32'(bif.voter_count), 32'(cnt));
        chk({tag, ".poll_closed"}, 32'(bif.poll_closed), 32'(closed));
        chk({tag, ".err_multi"},   32'(bif.err_multi),   32'(err));
        chk({tag, ".timeout_evt"}, 32'(bif.timeout_evt), 32'(tmo));
    endtask

    initial begin
        reset          = 1'b0;
        bif.auth_pin   = 1'b0;
        bif.cand_sel   = 4'b0000;
        bif.confirm    = 1'b0;
        bif.cancel     = 1'b0;
        bif.close_poll = 1'b0;
        step(2);
        chk_all("reset", 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);

        // Normal vote for candidate 2.
        bif.auth_pin = 1'b1;
        step(1);
        chk_all("s1_select", 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b0100;
        step(1);
        chk_all("s1_review", 4'b0000, 1'b1, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.cand_sel = 4'b0000;
        bif.confirm  = 1'b1;
        step(1);
        chk_all("s1_commit", 4'b0000, 1'b0, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.confirm = 1'b0;
        step(1);
        chk_all("s1_vote", 4'b0100, 1'b0, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("s1_idle", 4'b0000, 1'b0, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0);

        // Multi-hot rejected, then a valid pick held through commit.
        bif.auth_pin = 1'b1;
        step(1);
        chk_all("s2_select", 4'b0000, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b0110;
        step(1);
        chk_all("s2_multi", 4'b0000, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b1, 1'b0);
        bif.cand_sel = 4'b0001;
        step(1);
        chk_all("s2_review", 4'b0000, 1'b1, 4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);
        bif.confirm = 1'b1;
        step(1);
        chk_all("s2_commit", 4'b0000, 1'b0, 4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("s2_vote", 4'b0001, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_all("s2_held", 4'b0000, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);
        end
        bif.cand_sel = 4'b0000;
        bif.confirm  = 1'b0;
        step(1);
        chk_all("s2_idle", 4'b0000, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);

        // Idle timeout in SELECT: abandoned at the end of the 16th cycle.
        bif.auth_pin = 1'b1;
        step(1);
        chk_all("to_select", 4'b0000, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);
        bif.auth_pin = 1'b0;
        step(15);
        chk_all("to_before", 4'b0000, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_all("to_event", 4'b0000, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b1);
        step(1);
        chk_all("to_idle", 4'b0000, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0);

        // Third session reaches the turnout limit.
        bif.auth_pin = 1'b1;
        step(1);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b1000;
        step(1);
        chk_all("s3_review", 4'b0000, 1'b1, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b0);
        bif.cand_sel = 4'b0000;
        bif.confirm  = 1'b1;
        step(1);
        bif.confirm = 1'b0;
        step(1);
        chk_all("s3_vote", 4'b1000, 1'b0, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b0);
        bif.auth_pin = 1'b1;
        bif.cand_sel = 4'b0001;
        bif.confirm  = 1'b1;
        step(3);
        chk_all("closed_ignore", 4'b0000, 1'b0, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b0);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b0000;
        bif.confirm  = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        reset = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1);
        reset = 1'b1;
        step(1);

        // Close request during REVIEW is deferred until the vote commits.
        bif.auth_pin = 1'b1;
        step(1);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b0010;
        step(1);
        bif.cand_sel   = 4'b0000;
        bif.close_poll = 1'b1;
        step(1);
        chk_all("s4_pending", 4'b0000, 1'b1, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.close_poll = 1'b0;
        bif.confirm    = 1'b1;
        step(1);
        chk_all("s4_commit", 4'b0000, 1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.confirm = 1'b0;
        step(1);
        chk_all("s4_vote", 4'b0010, 1'b0, 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0);
        step(2);
        chk_all("s4_closed", 4'b0000, 1'b0, 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0);

        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);

        // Cancel in REVIEW, re-select, then reset while confirm is pressed.
        bif.auth_pin = 1'b1;
        step(1);
        bif.auth_pin = 1'b0;
        bif.cand_sel = 4'b0100;
        step(1);
        bif.cand_sel = 4'b0000;
        bif.cancel   = 1'b1;
        step(1);
        chk_all("s5_cancel", 4'b0000, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.cancel   = 1'b0;
        bif.cand_sel = 4'b0100;
        step(1);
        chk_all("s5_review", 4'b0000, 1'b1, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b0);
        bif.cand_sel = 4'b0000;
        bif.confirm  = 1'b1;
        reset        = 1'b0;
        #1;
        chk_all("s5_reset", 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        chk_all("s5_reset_hold", 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        reset       = 1'b1;
        bif.confirm = 1'b0;
        step(2);
        chk_all("s5_after", 4'b0000, 1'b0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ballot_session_ctrl.md
# ballot_session_ctrl

Per-voter session sequencer in front of the vote tally datapath. It gates authentication, candidate selection, confirmation and commit so that each authenticated voter produces at most one single-cycle tally increment. It enforces per-session timeout, total turnout limit and poll closure. It sits between the debounced button/auth inputs and the per-candidate tally counters and display.

## Interface
- NUM_CAND, 4, number of candidates (2..8)
- CNT_W, 4, width of voter_count
- MAX_TURNOUT, 10, voters allowed before automatic close (1..2^CNT_W-1)
- TIMEOUT_CYC, 50000000, idle cycles allowed in SELECT/REVIEW before the session is abandoned (≥2)
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- auth_pin  input  1  debounced authentication level
- cand_sel  input  NUM_CAND  debounced candidate buttons, level
- confirm  input  1  debounced confirm button
- cancel  input  1  debounced cancel button
- close_poll  input  1  operator close request, level or pulse
- vote_inc  output  NUM_CAND  one-hot, one-cycle increment strobe to tally
- ballot_open  output  1  high in SELECT and REVIEW
- sel_q  output  NUM_CAND  latched selection, valid in REVIEW/COMMIT, else 0
- voter_count  output  CNT_W  committed sessions
- poll_closed  output  1  high in CLOSED
- err_multi  output  1  one-cycle pulse: multi-hot selection rejected
- timeout_evt  output  1  one-cycle pulse: session abandoned by timeout

## Operation
- States: IDLE, SELECT, REVIEW, COMMIT, RELEASE, CLOSED. All outputs registered.
- IDLE: auth_pin=1 → SELECT. close_poll or close_pend → CLOSED (takes priority over auth_pin).
- SELECT: cancel → IDLE. Exactly one cand_sel bit → latch sel_q, → REVIEW. Multi-hot → err_multi pulse, stay. Timer expiry → IDLE + timeout_evt.
- REVIEW: priority cancel > confirm > timeout. cancel → SELECT, sel_q cleared. confirm → COMMIT. Expiry → IDLE + timeout_evt, sel_q cleared.
- COMMIT: exactly one cycle. vote_inc=sel_q, voter_count+1. Next state: CLOSED if new count == MAX_TURNOUT or close_pend, else RELEASE.
- RELEASE: waits until auth_pin, confirm and all cand_sel are 0, then → IDLE. Prevents a held button from starting or completing a second session.
- CLOSED: absorbing until reset. Inputs ignored, vote_inc=0.
- close_poll in SELECT/REVIEW sets close_pend. The session still completes or is abandoned, then the block goes to CLOSED instead of IDLE/RELEASE. close_poll in RELEASE → CLOSED immediately.
- Timer: counts cycles while in SELECT/REVIEW. Cleared on every state change and on cancel. Expiry when timer == TIMEOUT_CYC-1. Width $clog2(TIMEOUT_CYC).
- voter_count never wraps: CLOSED is entered at MAX_TURNOUT.

## Timing
- Reset values: state IDLE, vote_inc 0, ballot_open 0, sel_q 0, voter_count 0, poll_closed 0, err_multi 0, timeout_evt 0, close_pend 0, timer 0.
- auth_pin sampled high at edge N → ballot_open=1 after edge N.
- confirm sampled in REVIEW at edge N → vote_inc asserted for exactly the cycle after edge N+1. voter_count updates on the same edge.
- Minimum session: 4 cycles from auth to vote_inc, plus RELEASE.
- Reset asserted mid-session discards the session with no vote_inc. voter_count returns to 0.

## Configuration
- BALLOT_ABSTAIN_EN defined: confirm in SELECT with cand_sel==0 → COMMIT with vote_inc=0. voter_count still increments, and abstain_evt (extra 1-bit output) pulses in COMMIT.
- BALLOT_ABSTAIN_EN undefined: confirm in SELECT is ignored, no abstain_evt port exists.

## Structure
- Shared package ballot_pkg: state enum (6 states, 3 bits), encode constants, one-hot check function.
- One sub-module, ballot_timeout_timer: parameter TIMEOUT_CYC, inputs run/clear, output expire.
- FSM, sel_q, voter_count and close_pend live in the top.

## Test plan
- Normal vote: auth, cand_sel=0100, confirm, release all → single vote_inc=0100 pulse, voter_count 0→1, back to IDLE.
- Multi-hot: cand_sel=0110 in SELECT → err_multi one pulse, no vote_inc. Then cand_sel=0001 → REVIEW, sel_q=0001.
- Timeout: TIMEOUT_CYC=16, auth then no input → timeout_evt on the 16th SELECT cycle, IDLE, voter_count unchanged.
- Held button: keep cand_sel=0001 and confirm high after COMMIT → stays in RELEASE, no second vote_inc.
- Turnout: MAX_TURNOUT=3, three complete sessions → poll_closed=1 after third COMMIT. Fourth auth ignored.
- close_poll during REVIEW, then confirm → vote_inc fires once, then CLOSED. Async reset mid-REVIEW → all outputs at reset values, no vote_inc.
